// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Two-entry pipeline stage register with skid buffer (e.g. the ID/EX slot).
// The main register M drives out_data directly; the skid register S absorbs
// one entry when downstream backpressure arrives. This keeps in_ready a
// function of registered state only, so in_ready has no path from out_ready.
// flush kills both entries and takes priority over everything. stall
// freezes the stage. A saturating counter counts bubble cycles.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous, active-high reset
//   flush       kill all held entries (branch/jump redirect)
//   stall       freeze stage: no accept, no emit
//   in_valid    upstream entry valid
//   in_ready    stage can accept this cycle
//   in_data     upstream payload [DATA_W]
//   out_valid   out_data holds a valid entry
//   out_ready   downstream takes the entry this cycle
//   out_data    payload of the main entry, driven directly from a register
//   occupancy   entries held (0..2)
//   bubble_cnt  non-stalled cycles with out_valid=0, saturating [CNT_W]
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W         = 128,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // State. S is only ever valid while M is valid, so the pair of valid
  // bits fully encodes occupancy 0/1/2.
  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0]  bubble_q,  bubble_d;

  logic accept;
  logic emit;
  logic bubble_inc;

  // Handshake outputs. in_ready does not depend on in_valid, and neither
  // output depends on the opposite side's handshake input.
  assign in_ready  = ~s_valid_q & ~stall & ~flush;
  assign out_valid =  m_valid_q & ~stall & ~flush;

  assign accept = in_valid  & in_ready;
  assign emit   = out_valid & out_ready;

  assign out_data   = m_data_q;
  assign occupancy  = {s_valid_q, m_valid_q & ~s_valid_q};
  assign bubble_cnt = bubble_q;

  // Next-state logic for the two entries.
  always_comb begin
    // NOTE: every variable gets a hold default first so that no path through
    // the case below leaves it unassigned, which would infer a latch.
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else begin
      // stall forces accept=emit=0, so the default hold covers it.
      // Payload registers load only on real transfers to limit toggling.
      unique case ({s_valid_q, m_valid_q})
        2'b00: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
          end
        end
        2'b01: begin
          if (accept && emit) begin
            m_data_d  = in_data;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
          end else if (emit) begin
            // out_data keeps showing the last value.
            m_valid_d = 1'b0;
          end
        end
        2'b11: begin
          // in_ready is low here, so only an emit can happen.
          if (emit) begin
            s_valid_d = 1'b0;
            m_data_d  = s_data_q;
          end
        end
        default: begin
          // S valid without M valid cannot be reached; recover to empty.
          m_valid_d = 1'b0;
          s_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Bubble counter. A flush always counts as a bubble, even with stall
  // high, because a simultaneous flush and stall behaves as a flush.
  assign bubble_inc = flush | (~stall & ~out_valid);

  always_comb begin
    bubble_d = bubble_q;
    if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  // NOTE: the payload registers are reset as well as the valid bits, so
  // out_data reads zero during and right after reset rather than stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      bubble_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      bubble_q  <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. A table of per-cycle vectors covers
// streaming, backpressure, flush, stall and flush+stall; hand-written
// sequences cover asynchronous reset and bubble counter saturation. A second
// instance with CNT_W=4 shares all inputs and is used for saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_bubble_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_data    (in_data),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_data   (s_out_data),
    .occupancy  (s_occupancy),
    .bubble_cnt (s_bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          exp_in_ready;
    logic          exp_out_valid;
    logic [DW-1:0] exp_out_data;
    logic [1:0]    exp_occ;
    logic          bub_chk;
    logic [15:0]   exp_bub;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic f, input logic s, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
    flush     = f;
    stall     = s;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic setv(input int i, input logic f, input logic s, input logic iv,
                      input logic [DW-1:0] d, input logic ordy, input logic eir,
                      input logic eov, input logic [DW-1:0] eod, input logic [1:0] eocc,
                      input logic bc, input logic [15:0] eb);
    vecs[i] = '{f, s, iv, d, ordy, eir, eov, eod, eocc, bc, eb};
  endtask

  initial begin
    // Expected outputs are those seen during the cycle, before the edge
    // that consumes the inputs of the same vector.
    //        i  fl st iv data   or  ir ov odata  occ bc bub
    // streaming 1..4
    setv( 0, 0, 0, 1, 32'h1, 1,  1, 0, 32'h0, 0,  1, 0);
    setv( 1, 0, 0, 1, 32'h2, 1,  1, 1, 32'h1, 1,  1, 1);
    setv( 2, 0, 0, 1, 32'h3, 1,  1, 1, 32'h2, 1,  1, 1);
    setv( 3, 0, 0, 1, 32'h4, 1,  1, 1, 32'h3, 1,  1, 1);
    setv( 4, 0, 0, 0, 32'h0, 1,  1, 1, 32'h4, 1,  1, 1);
    setv( 5, 0, 0, 0, 32'h0, 0,  1, 0, 32'h4, 0,  1, 1);
    // backpressure A, B, C refused, then drain
    setv( 6, 0, 0, 1, 32'hA, 0,  1, 0, 32'h4, 0,  1, 2);
    setv( 7, 0, 0, 1, 32'hB, 0,  1, 1, 32'hA, 1,  1, 3);
    setv( 8, 0, 0, 1, 32'hC, 0,  0, 1, 32'hA, 2,  1, 3);
    setv( 9, 0, 0, 0, 32'h0, 1,  0, 1, 32'hA, 2,  1, 3);
    setv(10, 0, 0, 0, 32'h0, 1,  1, 1, 32'hB, 1,  1, 3);
    setv(11, 0, 0, 0, 32'h0, 0,  1, 0, 32'hB, 0,  1, 3);
    // flush at occupancy 2 with in_valid high
    setv(12, 0, 0, 1, 32'hA, 0,  1, 0, 32'hB, 0,  1, 4);
    setv(13, 0, 0, 1, 32'hB, 0,  1, 1, 32'hA, 1,  1, 5);
    setv(14, 1, 0, 1, 32'h7, 1,  0, 0, 32'hA, 2,  1, 5);
    setv(15, 0, 0, 0, 32'h0, 0,  1, 0, 32'h0, 0,  1, 6);
    // stall 3 cycles holding 0x5
    setv(16, 0, 0, 1, 32'h5, 0,  1, 0, 32'h0, 0,  1, 7);
    setv(17, 0, 1, 1, 32'h9, 1,  0, 0, 32'h5, 1,  1, 8);
    setv(18, 0, 1, 1, 32'h9, 1,  0, 0, 32'h5, 1,  1, 8);
    setv(19, 0, 1, 1, 32'h9, 1,  0, 0, 32'h5, 1,  1, 8);
    setv(20, 0, 0, 0, 32'h0, 1,  1, 1, 32'h5, 1,  1, 8);
    setv(21, 0, 0, 0, 32'h0, 0,  1, 0, 32'h5, 0,  1, 8);
    // simultaneous flush and stall behaves as flush
    setv(22, 0, 0, 1, 32'h6, 0,  1, 0, 32'h5, 0,  1, 9);
    setv(23, 1, 1, 1, 32'h8, 1,  0, 0, 32'h6, 1,  1, 10);
    setv(24, 0, 0, 0, 32'h0, 0,  1, 0, 32'h0, 0,  0, 0);

    // Reset: state must be clear while rst is high.
    rst = 1'b1;
    set_in(0, 0, 0, '0, 0);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_bubble",    64'(bubble_cnt), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 25; i++) begin
      set_in(vecs[i].flush, vecs[i].stall, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      #1;
      check($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].exp_in_ready));
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      check($sformatf("v%0d_out_data", i),  64'(out_data),  64'(vecs[i].exp_out_data));
      check($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      if (vecs[i].bub_chk) begin
        check($sformatf("v%0d_bubble", i), 64'(bubble_cnt), 64'(vecs[i].exp_bub));
      end
      tick();
    end

    // Async reset between edges while holding two entries.
    set_in(0, 0, 1, 32'h11, 0);
    tick();
    set_in(0, 0, 1, 32'h22, 0);
    tick();
    set_in(0, 0, 0, '0, 0);
    #1;
    check("ar_pre_occupancy", 64'(occupancy), 64'd2);
    check("ar_pre_out_data",  64'(out_data),  64'h11);
    #1;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_out_data",  64'(out_data),  64'd0);
    check("ar_occupancy", 64'(occupancy), 64'd0);
    check("ar_bubble",    64'(bubble_cnt), 64'd0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0, '0, 1);
    repeat (5) tick();
    check("ar_idle5_bubble",    64'(bubble_cnt), 64'd5);
    check("ar_idle5_out_valid", 64'(out_valid),  64'd0);
    check("ar_idle5_out_data",  64'(out_data),   64'd0);
    check("ar_idle5_in_ready",  64'(in_ready),   64'd1);
    check("sat_idle5_bubble",   64'(s_bubble_cnt), 64'd5);

    // Saturation of the 4-bit counter after 20 idle cycles, then held.
    repeat (15) tick();
    check("sat_idle20_bubble",  64'(s_bubble_cnt), 64'd15);
    check("main_idle20_bubble", 64'(bubble_cnt),   64'd20);
    repeat (5) tick();
    check("sat_idle25_bubble",  64'(s_bubble_cnt), 64'd15);
    check("main_idle25_bubble", 64'(bubble_cnt),   64'd25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
